// File: rtl/light_pkg.sv
// Shared constants and colour mapping for the light PWM driver.
// Optional square-law colour map is selected by LIGHT_PWM_GAMMA_EN.
package light_pkg;

    localparam logic [7:0] PWM_LAST = 8'd254;

    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    // (c*c + c) >> 8 pins both ends: 0 maps to 0 and 255 maps to 255.
    function automatic logic [7:0] gamma8(input logic [7:0] c);
        logic [15:0] sq;
        sq = 16'(c) * 16'(c) + 16'(c);
        return sq[15:8];
    endfunction

endpackage

// File: rtl/light_pwm_driver_if.sv
// Colour bus from the lights selector plus the RGB LED drive it produces.
interface light_pwm_driver_if;
    logic [23:0] light;
    logic        led_r;
    logic        led_g;
    logic        led_b;
    logic        period_start;

    modport master (output light, input led_r, led_g, led_b, period_start);
    modport slave  (input light, output led_r, led_g, led_b, period_start);
endinterface

// File: rtl/light_pwm_driver_channel.sv
// One LED channel: duty register loaded at period wrap, comparator, output flop.
// Field mapping is square-law when LIGHT_PWM_GAMMA_EN is defined, linear otherwise.
module pwm_channel
    import light_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] field,
    input  logic [7:0] pwm_cnt_next,
    output logic       led
);

    logic [7:0] mapped;
    logic [7:0] duty_d, duty_q;
    logic       led_d, led_q;

    always_comb begin
`ifdef LIGHT_PWM_GAMMA_EN
        mapped = gamma8(field);
`else
        mapped = field;
`endif
        duty_d = load ? mapped : duty_q;
        // Comparing against next-cycle values keeps the pin registered yet aligned.
        led_d  = (pwm_cnt_next < duty_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= 8'd0;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/light_pwm_driver.sv
// Converts the 24-bit light colour word into three glitch-free PWM LED drives.
// Build option: LIGHT_PWM_GAMMA_EN enables the square-law colour map in each channel.
module light_pwm_driver
    import light_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    light_pwm_driver_if.slave         bus
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] pre_cnt_d, pre_cnt_q;
    logic [7:0]       pwm_cnt_d, pwm_cnt_q;
    logic             period_start_d, period_start_q;
    logic             tick;
    logic             wrap;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        tick           = (pre_cnt_q == PRE_W'(PRESCALE - 1));
        wrap           = tick && (pwm_cnt_q == PWM_LAST);
        pre_cnt_d      = tick ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d      = pwm_cnt_q;
        if (wrap) begin
            pwm_cnt_d = 8'd0;
        end else if (tick) begin
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end
        period_start_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= 8'd0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.period_start = period_start_q;

    pwm_channel u_ch_r (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (wrap),
        .field        (bus.light[R_HI:R_LO]),
        .pwm_cnt_next (pwm_cnt_d),
        .led          (bus.led_r)
    );

    pwm_channel u_ch_g (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (wrap),
        .field        (bus.light[G_HI:G_LO]),
        .pwm_cnt_next (pwm_cnt_d),
        .led          (bus.led_g)
    );

    pwm_channel u_ch_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (wrap),
        .field        (bus.light[B_HI:B_LO]),
        .pwm_cnt_next (pwm_cnt_d),
        .led          (bus.led_b)
    );

endmodule

// File: tb/tb_light_pwm_driver.sv
// Self-checking bench for light_pwm_driver: PRESCALE=1 and PRESCALE=4 instances
// against an arithmetic model of the PWM timeline, plus literal period checks.
module tb_light_pwm_driver;

    logic clk;
    logic rst_n_a;
    logic rst_n_b;
    int   checks;
    int   errors;

`ifdef LIGHT_PWM_GAMMA_EN
    localparam int EXP_80 = 64;
    localparam int EXP_01 = 0;
`else
    localparam int EXP_80 = 128;
    localparam int EXP_01 = 1;
`endif

    light_pwm_driver_if if_a ();
    light_pwm_driver_if if_b ();

    light_pwm_driver #(.PRESCALE(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (if_a)
    );

    light_pwm_driver #(.PRESCALE(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int map_c(input int c);
`ifdef LIGHT_PWM_GAMMA_EN
        return (c * c + c) / 256;
`else
        return c;
`endif
    endfunction

    function automatic int fld(input logic [23:0] l, input int idx);
        return int'((l >> (8 * (2 - idx))) & 24'hFF);
    endfunction

    // Model: after edge k, the counter reads floor(k/P) mod 255; duty is the
    // colour captured at the most recent edge with k a multiple of 255*P.
    int ka, kb;
    int duty_a[3];
    int duty_b[3];

    always @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            ka     <= 0;
            duty_a <= '{0, 0, 0};
        end else begin
            ka <= ka + 1;
            if ((ka + 1) % 255 == 0)
                for (int i = 0; i < 3; i++) duty_a[i] <= map_c(fld(if_a.light, i));
        end
    end

    always @(posedge clk or negedge rst_n_b) begin
        if (!rst_n_b) begin
            kb     <= 0;
            duty_b <= '{0, 0, 0};
        end else begin
            kb <= kb + 1;
            if ((kb + 1) % 1020 == 0)
                for (int i = 0; i < 3; i++) duty_b[i] <= map_c(fld(if_b.light, i));
        end
    end

    always @(negedge clk) begin : cmp_a
        int pa;
        if (rst_n_a) begin
            pa = ka % 255;
            check("model_a_led_r", int'(if_a.led_r), int'(pa < duty_a[0]));
            check("model_a_led_g", int'(if_a.led_g), int'(pa < duty_a[1]));
            check("model_a_led_b", int'(if_a.led_b), int'(pa < duty_a[2]));
            check("model_a_period_start", int'(if_a.period_start), int'(ka > 0 && ka % 255 == 0));
        end
    end

    always @(negedge clk) begin : cmp_b
        int pb;
        if (rst_n_b) begin
            pb = (kb / 4) % 255;
            check("model_b_led_r", int'(if_b.led_r), int'(pb < duty_b[0]));
            check("model_b_led_g", int'(if_b.led_g), int'(pb < duty_b[1]));
            check("model_b_led_b", int'(if_b.led_b), int'(pb < duty_b[2]));
            check("model_b_period_start", int'(if_b.period_start), int'(kb > 0 && kb % 1020 == 0));
        end
    end

    // Samples n cycles on instance A, optionally changing light at sample chg_at.
    task automatic count_a(input int n, input int chg_at, input logic [23:0] new_light,
                           output int r, output int g, output int b, output int ps);
        r = 0; g = 0; b = 0; ps = 0;
        for (int i = 0; i < n; i++) begin
            if (i == chg_at) if_a.light = new_light;
            r  += int'(if_a.led_r);
            g  += int'(if_a.led_g);
            b  += int'(if_a.led_b);
            ps += int'(if_a.period_start);
            @(negedge clk);
        end
    endtask

    task automatic wait_ps_a();
        int found;
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (if_a.period_start) found = 1;
        end
        check("wait_period_start_a", found, 1);
    endtask

    task automatic check_period_a(input string tag, input int er, input int eg, input int eb,
                                  input int chg_at, input logic [23:0] new_light);
        int r, g, b, ps;
        count_a(255, chg_at, new_light, r, g, b, ps);
        check({tag, "_r_high"}, r, er);
        check({tag, "_g_high"}, g, eg);
        check({tag, "_b_high"}, b, eb);
        check({tag, "_ps_pulses"}, ps, 1);
        check({tag, "_next_ps"}, int'(if_a.period_start), 1);
    endtask

    task automatic run_a();
        int r, g, b, ps;
        rst_n_a    = 1'b0;
        if_a.light = 24'hFF8000;
        repeat (2) @(negedge clk);
        check("reset_led_r", int'(if_a.led_r), 0);
        check("reset_led_g", int'(if_a.led_g), 0);
        check("reset_led_b", int'(if_a.led_b), 0);
        check("reset_period_start", int'(if_a.period_start), 0);
        rst_n_a = 1'b1;
        @(negedge clk);
        count_a(254, -1, 24'h0, r, g, b, ps);
        check("dark_first_r", r, 0);
        check("dark_first_g", g, 0);
        check("dark_first_b", b, 0);
        check("dark_first_ps", ps, 0);
        check("edge255_ps", int'(if_a.period_start), 1);
        check("edge255_led_r", int'(if_a.led_r), 1);
        check("edge255_led_g", int'(if_a.led_g), 1);
        check("edge255_led_b", int'(if_a.led_b), 0);
        check_period_a("ff8000_p1", 255, EXP_80, 0, -1, 24'h0);
        check_period_a("ff8000_p2", 255, EXP_80, 0, -1, 24'h0);

        if_a.light = 24'h000000;
        wait_ps_a();
        check_period_a("black", 0, 0, 0, -1, 24'h0);
        if_a.light = 24'hFFFFFF;
        wait_ps_a();
        check_period_a("white", 255, 255, 255, -1, 24'h0);

        if_a.light = 24'h0000FF;
        wait_ps_a();
        check_period_a("blue_midchange", 0, 0, 255, 100, 24'h00FF00);
        check_period_a("green_after", 0, 255, 0, -1, 24'h0);

`ifdef LIGHT_PWM_GAMMA_EN
        if_a.light = 24'h80FF00;
        wait_ps_a();
        check_period_a("gamma_80ff00", 64, 255, 0, -1, 24'h00FF00);
        wait_ps_a();
`endif

        repeat (50) @(negedge clk);
        check("pre_reset_led_g", int'(if_a.led_g), 1);
        #2 rst_n_a = 1'b0;
        #1;
        check("async_reset_led_r", int'(if_a.led_r), 0);
        check("async_reset_led_g", int'(if_a.led_g), 0);
        check("async_reset_led_b", int'(if_a.led_b), 0);
        check("async_reset_ps", int'(if_a.period_start), 0);
        @(negedge clk);
        rst_n_a = 1'b1;
        @(negedge clk);
        count_a(254, -1, 24'h0, r, g, b, ps);
        check("dark_again_g", g, 0);
        check("dark_again_ps", ps, 0);
        check("rewrap_ps", int'(if_a.period_start), 1);
        check("rewrap_led_g", int'(if_a.led_g), 1);
    endtask

    task automatic run_b();
        int n, r, g, b, ps;
        rst_n_b    = 1'b0;
        if_b.light = 24'h010101;
        repeat (2) @(negedge clk);
        rst_n_b = 1'b1;
        n = 0;
        for (int i = 1; i <= 1100 && n == 0; i++) begin
            @(negedge clk);
            if (if_b.period_start) n = i;
        end
        check("p4_first_wrap_edge", n, 1020);
        for (int p = 0; p < 2; p++) begin
            r = 0; g = 0; b = 0; ps = 0;
            for (int i = 0; i < 1020; i++) begin
                r  += int'(if_b.led_r);
                g  += int'(if_b.led_g);
                b  += int'(if_b.led_b);
                ps += int'(if_b.period_start);
                @(negedge clk);
            end
            check("p4_r_high", r, 4 * EXP_01);
            check("p4_g_high", g, 4 * EXP_01);
            check("p4_b_high", b, 4 * EXP_01);
            check("p4_ps_pulses", ps, 1);
            check("p4_ps_spacing", int'(if_b.period_start), 1);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n_a    = 1'b0;
        rst_n_b    = 1'b0;
        if_a.light = 24'h0;
        if_b.light = 24'h0;
        fork
            run_a();
            run_b();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
